// File: rtl/bram_window_ctrl.sv
// Load/scan sequencer for the 3-read-port convolution BRAM.
// Loads one image from a pixel stream, then emits every 3x3 window in raster order.
module bram_window_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_PORTS  = 3,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic                            i_pix_valid,
    input  logic [RAM_WIDTH-1:0]            i_pix,
    output logic                            o_pix_ready,
    output logic                            o_wr_en,
    output logic [ADDR_WIDTH-1:0]           o_w_addrs,
    output logic [RAM_WIDTH-1:0]            o_w_data,
    output logic [ADDR_WIDTH*RAM_PORTS-1:0] o_r_addrs,
    input  logic [RAM_WIDTH*RAM_PORTS-1:0]  i_bram_data,
    output logic [RAM_WIDTH*9-1:0]          o_win,
    output logic                            o_win_valid,
    input  logic                            i_win_ready,
    output logic                            o_busy,
    output logic                            o_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD,
        ST_DRAIN,
        ST_OUT,
        ST_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PIX_LAST = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_WIDTH-1:0] IMG_W_A  = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_W - 3);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(IMG_H - 3);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0]           wcnt_reg;
    logic [ADDR_WIDTH-1:0]           row_reg;
    logic [ADDR_WIDTH-1:0]           col_reg;
    logic [1:0]                      k_reg;
    logic [ADDR_WIDTH*RAM_PORTS-1:0] r_addrs_reg;
    logic [RAM_WIDTH*9-1:0]          win_reg;
    logic                            done_reg;

    logic                            wr_en;
    logic                            load_last;
    logic                            win_hs;
    logic                            scan_last;
    logic                            cap_en;
    logic [1:0]                      cap_row;
    logic [ADDR_WIDTH-1:0]           row_base;
    logic [ADDR_WIDTH-1:0]           r_addr_next [RAM_PORTS];

    assign wr_en     = i_pix_valid && o_pix_ready;
    assign load_last = (wcnt_reg == PIX_LAST);
    assign win_hs    = o_win_valid && i_win_ready;
    assign scan_last = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

    // Row k of the current window starts at (r+k)*IMG_W + c; ports read 3 adjacent pixels.
    assign row_base = (row_reg + ADDR_WIDTH'(k_reg)) * IMG_W_A + col_reg;

    genvar gi;
    generate
        for (gi = 0; gi < RAM_PORTS; gi++) begin : g_raddr
            assign r_addr_next[gi] = row_base + ADDR_WIDTH'(gi);
        end
    endgenerate

    // Read data trails the address register by one cycle: RD k>0 captures row k-1, DRAIN row 2.
    assign cap_en  = ((state_reg == ST_RD) && (k_reg != 2'd0)) || (state_reg == ST_DRAIN);
    assign cap_row = (state_reg == ST_DRAIN) ? 2'd2 : (k_reg - 2'd1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (i_start) state_next = ST_LOAD;
            ST_LOAD:  if (wr_en && load_last) state_next = ST_RD;
            ST_RD:    if (k_reg == 2'd2) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_OUT;
            ST_OUT:   if (win_hs) state_next = scan_last ? ST_DONE : ST_RD;
            ST_DONE:  if (i_start) state_next = ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_pix_ready = 1'b0;
        o_win_valid = 1'b0;
        o_busy      = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                o_pix_ready = 1'b1;
                o_busy      = 1'b1;
            end
            ST_RD, ST_DRAIN: o_busy = 1'b1;
            ST_OUT: begin
                o_win_valid = 1'b1;
                o_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wcnt_reg <= '0;
            row_reg  <= '0;
            col_reg  <= '0;
            k_reg    <= 2'd0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == ST_OUT) && win_hs && scan_last;
            if (wr_en) begin
                wcnt_reg <= load_last ? '0 : wcnt_reg + ONE_A;
                if (load_last) begin
                    row_reg <= '0;
                    col_reg <= '0;
                end
            end
            if (state_reg == ST_RD) begin
                k_reg <= (k_reg == 2'd2) ? 2'd0 : k_reg + 2'd1;
            end
            if (win_hs) begin
                if (col_reg == COL_LAST) begin
                    col_reg <= '0;
                    row_reg <= scan_last ? '0 : row_reg + ONE_A;
                end else begin
                    col_reg <= col_reg + ONE_A;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addrs_reg <= '0;
        end else if (state_reg == ST_RD) begin
            for (int p = 0; p < RAM_PORTS; p++) begin
                r_addrs_reg[ADDR_WIDTH*p +: ADDR_WIDTH] <= r_addr_next[p];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            win_reg <= '0;
        end else if (cap_en) begin
            for (int k = 0; k < 3; k++) begin
                if (cap_row == 2'(k)) begin
                    win_reg[RAM_WIDTH*3*k +: RAM_WIDTH*3] <= i_bram_data;
                end
            end
        end
    end

    assign o_wr_en   = wr_en;
    assign o_w_addrs = wcnt_reg;
    assign o_w_data  = i_pix;
    assign o_r_addrs = r_addrs_reg;
    assign o_win     = win_reg;
    assign o_done    = done_reg;

endmodule

// File: tb/tb_bram_window_ctrl.sv
// Directed bench for bram_window_ctrl: loads an 8x8 ramp image into a behavioural BRAM,
// then checks every window, stalls, ignored starts, and a mid-scan reset.
module tb_bram_window_ctrl;

    localparam int AW    = 6;
    localparam int RW    = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int N_PIX = IMG_W * IMG_H;
    localparam int N_WIN = (IMG_W - 2) * (IMG_H - 2);

    logic              i_clk;
    logic              i_rst;
    logic              i_start;
    logic              i_pix_valid;
    logic [RW-1:0]     i_pix;
    logic              o_pix_ready;
    logic              o_wr_en;
    logic [AW-1:0]     o_w_addrs;
    logic [RW-1:0]     o_w_data;
    logic [AW*3-1:0]   o_r_addrs;
    logic [RW*3-1:0]   i_bram_data;
    logic [RW*9-1:0]   o_win;
    logic              o_win_valid;
    logic              i_win_ready;
    logic              o_busy;
    logic              o_done;

    int n_vec = 0;
    int n_err = 0;

    bram_window_ctrl #(
        .ADDR_WIDTH(AW), .RAM_WIDTH(RW), .RAM_PORTS(3), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_pix_valid(i_pix_valid), .i_pix(i_pix), .o_pix_ready(o_pix_ready),
        .o_wr_en(o_wr_en), .o_w_addrs(o_w_addrs), .o_w_data(o_w_data),
        .o_r_addrs(o_r_addrs), .i_bram_data(i_bram_data),
        .o_win(o_win), .o_win_valid(o_win_valid), .i_win_ready(i_win_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural BRAM: data for the registered read address is visible in the following cycle.
    logic [RW-1:0] mem [0:N_PIX-1];
    always @(posedge i_clk) if (o_wr_en) mem[o_w_addrs] <= o_w_data;
    always_comb begin
        i_bram_data = '0;
        for (int j = 0; j < 3; j++) i_bram_data[RW*j +: RW] = mem[o_r_addrs[AW*j +: AW]];
    end

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] exp_addrs(input int b);
        exp_addrs = {6'(b + 2), 6'(b + 1), 6'(b)};
    endfunction

    // Pixel n of the image holds n+1, so pixel(r,c) = r*IMG_W + c + 1.
    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
                w[RW*(3*k+j) +: RW] = 8'((r + k) * IMG_W + c + j + 1);
        return w;
    endfunction

    task automatic load_image(input bit gappy);
        int n = 0;
        int cyc = 0;
        int wr_seen = 0;
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
        while (n < N_PIX && cyc < 1000) begin
            i_pix_valid = gappy ? (cyc % 2 == 0) : 1'b1;
            i_pix = 8'(n + 1);
            @(negedge i_clk);
            check_val("wr_en", 72'(o_wr_en), 72'(i_pix_valid));
            if (o_wr_en) wr_seen++;
            if (i_pix_valid) check_val("wr_addr", 72'(o_w_addrs), 72'(n));
            @(posedge i_clk); #1;
            if (i_pix_valid) n++;
            cyc++;
        end
        i_pix_valid = 1'b0;
        check_val("wr_count", 72'(wr_seen), 72'(N_PIX));
        $display("load gappy=%0d: %0d writes in %0d cycles", gappy, wr_seen, cyc);
    endtask

    task automatic check_first_reads();
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            check_val("raddr_row", 72'(o_r_addrs), 72'(exp_addrs(k * IMG_W)));
        end
    endtask

    task automatic run_scan(input int stall_win, input bit poke, input int abort_win);
        int r = 0;
        int c = 0;
        int win = 0;
        int stall = 0;
        int cyc = 0;
        bit hs = 1'b0;
        bit fin = 1'b0;
        bit fresh = 1'b1;
        i_win_ready = 1'b1;
        while (!fin && cyc < 3000) begin
            @(posedge i_clk); #1;
            cyc++;
            i_start = 1'b0;
            if (hs) begin
                hs = 1'b0;
                if (win == N_WIN) begin
                    check_val("done_pulse", 72'(o_done), 72'(1));
                    fin = 1'b1;
                end else if (win == abort_win) begin
                    @(posedge i_clk); #1;
                    check_val("abort_raddr", 72'(o_r_addrs), 72'(exp_addrs(r * IMG_W + c)));
                    i_pix_valid = 1'b0;
                    i_rst = 1'b1;
                    #1;
                    check_val("rst_raddr", 72'(o_r_addrs), 72'(0));
                    check_val("rst_win", 72'(o_win), 72'(0));
                    check_val("rst_valid", 72'(o_win_valid), 72'(0));
                    check_val("rst_busy", 72'(o_busy), 72'(0));
                    check_val("rst_ready", 72'(o_pix_ready), 72'(0));
                    check_val("rst_done", 72'(o_done), 72'(0));
                    $display("reset during window (%0d,%0d)", r, c);
                    fin = 1'b1;
                end else begin
                    check_val("done_early", 72'(o_done), 72'(0));
                end
            end
            if (!fin) begin
                if (poke) check_val("wr_en_scan", 72'(o_wr_en), 72'(0));
                i_start = poke && (cyc % 3 == 0);
                i_pix_valid = poke;
                if (o_win_valid) begin
                    check_val("win_data", 72'(o_win), exp_win(r, c));
                    check_val("win_raddr", 72'(o_r_addrs), 72'(exp_addrs((r + 2) * IMG_W + c)));
                    if (fresh) $display("win %0d (%0d,%0d) %h", win, r, c, o_win);
                    fresh = 1'b0;
                    if (win == stall_win && stall < 4) begin
                        i_win_ready = 1'b0;
                        stall++;
                    end else begin
                        i_win_ready = 1'b1;
                        hs = 1'b1;
                        fresh = 1'b1;
                        win++;
                        if (c == IMG_W - 3) begin
                            c = 0;
                            r++;
                        end else begin
                            c++;
                        end
                    end
                end
            end
        end
        i_start = 1'b0;
        i_pix_valid = 1'b0;
        if (!fin) begin
            check_val("scan_timeout", 72'(0), 72'(1));
        end else if (win == N_WIN) begin
            @(posedge i_clk); #1;
            check_val("done_once", 72'(o_done), 72'(0));
            check_val("done_busy", 72'(o_busy), 72'(0));
            check_val("done_valid", 72'(o_win_valid), 72'(0));
            $display("scan complete: %0d windows", win);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_pix_valid = 1'b0;
        i_pix = '0;
        i_win_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_val("reset_busy", 72'(o_busy), 72'(0));
        check_val("reset_done", 72'(o_done), 72'(0));
        check_val("reset_valid", 72'(o_win_valid), 72'(0));
        check_val("reset_raddr", 72'(o_r_addrs), 72'(0));
        check_val("reset_win", 72'(o_win), 72'(0));
        check_val("reset_ready", 72'(o_pix_ready), 72'(0));
        i_rst = 1'b0;

        load_image(1'b0);
        check_first_reads();
        run_scan(-1, 1'b0, -1);

        load_image(1'b1);
        run_scan(1, 1'b1, -1);

        load_image(1'b0);
        run_scan(-1, 1'b0, 2 * (IMG_W - 2) + 3);
        repeat (2) @(posedge i_clk);
        #1;
        check_val("idle_busy", 72'(o_busy), 72'(0));
        i_rst = 1'b0;

        load_image(1'b0);
        check_first_reads();
        run_scan(-1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
